// File: rtl/poly_eval_seq_if.sv
// Operator-facing bus of poly_eval_seq: load strobe, data entry and result.
interface poly_eval_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
);
  localparam int CW = ($clog2(DEGREE + 1) > 1) ? $clog2(DEGREE + 1) : 1;

  logic             go;
  logic             keep_coeffs;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_result;
  logic             done;
  logic             busy;
  logic             overflow;
  logic [CW-1:0]    coeff_idx;

  // Operator / stimulus side
  modport master (
    output go, keep_coeffs, data_in,
    input  data_result, done, busy, overflow, coeff_idx
  );

  // Evaluator side
  modport slave (
    input  go, keep_coeffs, data_in,
    output data_result, done, busy, overflow, coeff_idx
  );
endinterface

// File: rtl/poly_eval_seq.sv
// Sequential polynomial evaluator: coefficients and x are entered one value
// per go press (high then low), then p(x) is computed by Horner's rule with
// one MUL and one ADD cycle per term, all arithmetic modulo 2^WIDTH.
module poly_eval_seq #(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic          clk,
  input  logic          resetn,
  poly_eval_seq_if.slave bus
);
  localparam int CW = ($clog2(DEGREE + 1) > 1) ? $clog2(DEGREE + 1) : 1;

  typedef enum logic [2:0] {
    LOAD_C, LOAD_C_WAIT, LOAD_X, LOAD_X_WAIT, INIT, MUL, ADD, DONE
  } state_t;

  state_t                     state, state_nx;
  logic [DEGREE:0][WIDTH-1:0] c;
  logic [WIDTH-1:0]           x, acc, res;
  logic [CW-1:0]              cidx, ti;
  logic                       ov_run, ov_out, done_q;
  logic [2*WIDTH-1:0]         prod;
  logic [WIDTH:0]             sum;

  // Full-width product and carry-extended sum; upper bits flag wrap-around
  assign prod = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, x};
  assign sum  = {1'b0, acc} + {1'b0, c[ti]};

  assign bus.data_result = res;
  assign bus.done        = done_q;
  assign bus.overflow    = ov_out;
  assign bus.coeff_idx   = cidx;
  assign bus.busy        = (state == INIT) || (state == MUL) ||
                           (state == ADD)  || (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= LOAD_C;
    else         state <= state_nx;
  end

  // Next-state: loads advance on go rising then falling; compute runs unconditionally
  always_comb begin
    state_nx = state;
    case (state)
      LOAD_C:      if (bus.go)  state_nx = LOAD_C_WAIT;
      LOAD_C_WAIT: if (!bus.go) state_nx = (cidx == '0) ? LOAD_X : LOAD_C;
      LOAD_X:      if (bus.go)  state_nx = LOAD_X_WAIT;
      LOAD_X_WAIT: if (!bus.go) state_nx = INIT;
      INIT:        state_nx = MUL;
      MUL:         state_nx = ADD;
      ADD:         state_nx = (ti == '0) ? DONE : MUL;
      DONE:        state_nx = bus.keep_coeffs ? LOAD_X : LOAD_C;
      default:     state_nx = LOAD_C;
    endcase
  end

  // Datapath: operand capture, Horner accumulate, result/flag publish in DONE.
  // The published overflow is a copy of the running flag so it holds with the
  // result until the next evaluation finishes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      c      <= '0;
      x      <= '0;
      acc    <= '0;
      res    <= '0;
      cidx   <= CW'(DEGREE);
      ti     <= '0;
      ov_run <= 1'b0;
      ov_out <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        LOAD_C:      c[cidx] <= bus.data_in;
        LOAD_C_WAIT: if (!bus.go && cidx != '0) cidx <= cidx - 1'b1;
        LOAD_X:      x <= bus.data_in;
        INIT: begin
          acc    <= c[DEGREE];
          ti     <= CW'(DEGREE - 1);
          ov_run <= 1'b0;
        end
        MUL: begin
          acc <= prod[WIDTH-1:0];
          if (|prod[2*WIDTH-1:WIDTH]) ov_run <= 1'b1;
        end
        ADD: begin
          acc <= sum[WIDTH-1:0];
          if (sum[WIDTH]) ov_run <= 1'b1;
          if (ti != '0) ti <= ti - 1'b1;
        end
        DONE: begin
          res    <= acc;
          ov_out <= ov_run;
          done_q <= 1'b1;
          if (!bus.keep_coeffs) cidx <= CW'(DEGREE);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/poly_eval_seq.md
POLY_EVAL_SEQ -- requirements
Module: poly_eval_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data, coefficient, x and result width in bits (>=4).
REQ-002 SHALL have parameter DEGREE, default 2: polynomial degree (>=1); DEGREE+1 coefficients c[DEGREE]..c[0].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 go  input  1  operator load strobe; high-then-low sequence commits one value.
REQ-006 keep_coeffs  input  1  sampled in DONE; 1 = next evaluation reuses stored coefficients, reloads x only.
REQ-007 data_in  input  WIDTH  value being loaded (coefficient or x), unsigned.
REQ-008 data_result  output  WIDTH  registered result p(x) mod 2^WIDTH.
REQ-009 done  output  1  registered one-cycle pulse, high in the cycle data_result first shows a new result.
REQ-010 busy  output  1  high in INIT, MUL, ADD, DONE.
REQ-011 overflow  output  1  registered sticky flag for the latest evaluation.
REQ-012 coeff_idx  output  max(1,$clog2(DEGREE+1))  index of coefficient currently being loaded.

Function
REQ-013 States: LOAD_C, LOAD_C_WAIT, LOAD_X, LOAD_X_WAIT, INIT, MUL, ADD, DONE.
REQ-014 LOAD_C: coefficient register c[coeff_idx] <= data_in every cycle; go=1 -> LOAD_C_WAIT, else stay.
REQ-015 LOAD_C_WAIT: no register load; go=1 stay; go=0 -> if coeff_idx==0 then LOAD_X, else coeff_idx-1 and LOAD_C.
REQ-016 Coefficients entered highest first: first committed value is c[DEGREE], last is c[0].
REQ-017 LOAD_X: x <= data_in every cycle; go=1 -> LOAD_X_WAIT; LOAD_X_WAIT: go=1 stay, go=0 -> INIT.
REQ-018 INIT: acc <= c[DEGREE]; term index i <= DEGREE-1; overflow <= 0; -> MUL.
REQ-019 MUL: acc <= (acc*x) mod 2^WIDTH; overflow set if full 2*WIDTH product > 2^WIDTH-1; -> ADD.
REQ-020 ADD: acc <= (acc+c[i]) mod 2^WIDTH; overflow set on carry out; i==0 -> DONE, else i-1 and -> MUL (Horner).
REQ-021 DONE: data_result <= acc, done <= 1 next cycle; keep_coeffs=1 -> LOAD_X, else coeff_idx <= DEGREE and -> LOAD_C.
REQ-022 Latency: go=0 sampled in LOAD_X_WAIT at edge E0; data_result valid and done=1 after edge E0+2+2*DEGREE (6 cycles for DEGREE=2).
REQ-023 done high exactly one cycle per evaluation; data_result and overflow hold until next DONE.
REQ-024 overflow is sticky within an evaluation only; cleared in INIT, never by load states.
REQ-025 go ignored in INIT, MUL, ADD, DONE; a go held high into LOAD_X/LOAD_C after DONE is treated as a new press (moves to WAIT state).
REQ-026 All arithmetic unsigned; intermediate results truncated to WIDTH bits; no saturation.
REQ-027 Coefficient and x registers retain values across evaluations until reloaded.

Reset
REQ-028 resetn=0 at a rising edge: state <= LOAD_C, coeff_idx <= DEGREE, all c[], x, acc <= 0, data_result <= 0, done <= 0, overflow <= 0, busy = 0.
REQ-029 Reset SHALL take priority in any state, including mid-computation (MUL/ADD) and while go=1; no partial result reaches data_result.

Verification
REQ-030 WIDTH=8, DEGREE=2: load c2=1, c1=2, c0=3, x=4 via go pulses -> data_result=0x1B, overflow=0, done one cycle exactly 6 cycles after final go fall.
REQ-031 Then keep_coeffs=1 in DONE, load x=5 only -> data_result=0x26 (38), coeff_idx unchanged, no LOAD_C visited.
REQ-032 c2=16, c1=0, c0=5, x=16 -> product 256 wraps: data_result=0x05, overflow=1; next evaluation 1,2,3,x=4 -> overflow=0.
REQ-033 resetn=0 during MUL of an evaluation -> next cycle data_result=0, done=0, busy=0, coeff_idx=DEGREE, state LOAD_C.
REQ-034 WIDTH=16, DEGREE=3: c3=2, c2=0, c1=0, c0=1, x=10 -> data_result=0x07D1, done after 8 cycles.
REQ-035 go held high for 10 cycles in LOAD_C_WAIT -> single commit, coeff_idx decrements by exactly 1 after go falls.
